// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: fixed priority to the pipeline
// writeback, with a starvation guard for the multi-cycle unit.
module rf_write_arbiter #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [REG_ID_W-1:0] req0_reg,
  input  logic [XLEN-1:0]     req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [REG_ID_W-1:0] req1_reg,
  input  logic [XLEN-1:0]     req1_data,
  output logic                req1_ready,
  output logic                rf_write_enable,
  output logic [REG_ID_W-1:0] rf_write_reg,
  output logic [XLEN-1:0]     rf_write_data,
  output logic                boost
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]    wait_cnt;
  logic [REG_ID_W-1:0] sel_reg;
  logic [XLEN-1:0]     sel_data;
  logic                accept;
  logic                write;
  logic                blocked;

  assign boost = !rst && (wait_cnt == WAIT_MAX);

  assign req1_ready = !rst && req1_valid &&
                      (boost || !req0_valid);
  assign req0_ready = !rst && req0_valid && !req1_ready;

  assign blocked = req1_valid && !req1_ready;

  always_comb begin
    sel_reg  = req0_reg;
    sel_data = req0_data;
    if (req1_ready) begin
      sel_reg  = req1_reg;
      sel_data = req1_data;
    end
    accept = req0_ready || req1_ready;
    // x0 writes complete the handshake but leave the port untouched
    write  = accept && (sel_reg != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt        <= '0;
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
    end else begin
      if (blocked) begin
        if (wait_cnt != WAIT_MAX)
          wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      rf_write_enable <= write;
      if (write) begin
        rf_write_reg  <= sel_reg;
        rf_write_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios then random traffic
// against a transaction-level model with a reference register file.
module tb_rf_write_arbiter;

  localparam int XLEN     = 32;
  localparam int REG_ID_W = 5;
  localparam int MAX_WAIT = 3;
  localparam int CNT_W    = 4;

  logic                clk;
  logic                rst;
  logic                req0_valid;
  logic [REG_ID_W-1:0] req0_reg;
  logic [XLEN-1:0]     req0_data;
  logic                req0_ready;
  logic                req1_valid;
  logic [REG_ID_W-1:0] req1_reg;
  logic [XLEN-1:0]     req1_data;
  logic                req1_ready;
  logic                rf_write_enable;
  logic [REG_ID_W-1:0] rf_write_reg;
  logic [XLEN-1:0]     rf_write_data;
  logic                boost;

  rf_write_arbiter #(
    .XLEN(XLEN), .REG_ID_W(REG_ID_W),
    .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_write_enable(rf_write_enable),
    .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data),
    .boost(boost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: consecutive cycles req1 has been refused, expected port state
  int            blocked = 0;
  logic          m_en    = 1'b0;
  logic [4:0]    m_reg   = '0;
  logic [31:0]   m_data  = '0;
  logic [31:0]   rf_ref[32];
  logic [31:0]   rf_dut[32];
  logic          g0, g1;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic v0, input logic [4:0] a0,
                      input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1,
                      input logic [31:0] d1);
    logic eb, e0, e1;
    logic [4:0]  ar;
    logic [31:0] ad;
    @(negedge clk);
    rst        = r;
    req0_valid = v0; req0_reg = a0; req0_data = d0;
    req1_valid = v1; req1_reg = a1; req1_data = d1;
    #1;
    eb = !r && (blocked >= MAX_WAIT);
    e1 = !r && v1 && (eb || !v0);
    e0 = !r && v0 && !e1;
    check("req0_ready", 64'(req0_ready), 64'(e0));
    check("req1_ready", 64'(req1_ready), 64'(e1));
    check("boost", 64'(boost), 64'(eb));
    g0 = req0_ready;
    g1 = req1_ready;
    if (r) begin
      blocked = 0;
      m_en = 1'b0; m_reg = '0; m_data = '0;
    end else begin
      blocked = (v1 && !e1) ? blocked + 1 : 0;
      ar = e0 ? a0 : a1;
      ad = e0 ? d0 : d1;
      m_en = (e0 || e1) && (ar != 0);
      if (m_en) begin
        m_reg = ar; m_data = ad;
        rf_ref[ar] = ad;
      end
    end
    @(posedge clk);
    #1;
    check("wr_en", 64'(rf_write_enable), 64'(m_en));
    check("wr_reg", 64'(rf_write_reg), 64'(m_reg));
    check("wr_data", 64'(rf_write_data), 64'(m_data));
    if (rf_write_enable)
      rf_dut[rf_write_reg] = rf_write_data;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int p0, p1;
    logic [4:0]  ra0, ra1;
    logic [31:0] rd0, rd1;
    logic        r;
    for (int i = 0; i < 32; i++) begin
      rf_ref[i] = '0;
      rf_dut[i] = '0;
    end
    rst = 1'b1;
    req0_valid = 0; req0_reg = 0; req0_data = 0;
    req1_valid = 0; req1_reg = 0; req1_data = 0;

    // reset with both requesters pending
    step(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    step(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    idle();

    // single pipeline write, then idle drops enable
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check("t2_en", 64'(rf_write_enable), 64'd1);
    check("t2_data", 64'(rf_write_data), 64'hDEADBEEF);
    idle();
    check("t2_en_drop", 64'(rf_write_enable), 64'd0);

    // sustained contention: req1 wins every MAX_WAIT+1 cycles
    rd1 = 32'hA000;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 5'(i + 8), 32'(i), 1'b1, 5'd20, rd1);
      check("t3_grant1", 64'(g1), 64'((i % 4) == 3));
      if (g1) rd1 = rd1 + 1;
    end

    // x0 write from req1 leaves the port holding its last write
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    check("t4_ready", 64'(g1), 64'd1);
    check("t4_en", 64'(rf_write_enable), 64'd0);
    check("t4_hold", 64'(rf_write_data), 64'hA001);

    // reset mid-contention discards starvation history
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b1, 5'd6, 32'(100 + i), 1'b1, 5'd9, 32'h5555);
    step(1'b1, 1'b1, 5'd6, 32'd102, 1'b1, 5'd9, 32'h5555);
    check("t5_zero", 64'(rf_write_data), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 5'd6, 32'(200 + i), 1'b1, 5'd9, 32'h5555);
      check("t5_grant1", 64'(g1), 64'(i == 3));
    end

    // dropping valid for a cycle restarts the wait
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b1, 5'd10, 32'(300 + i), 1'b1, 5'd11, 32'h77);
    step(1'b0, 1'b1, 5'd10, 32'd302, 1'b0, 5'd11, 32'h77);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 5'd10, 32'(400 + i), 1'b1, 5'd11, 32'h77);
      check("t6_grant1", 64'(g1), 64'(i == 3));
    end

    // same destination: later grant persists
    step(1'b0, 1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hBBBB);
    check("same_dst", 64'(rf_write_data), 64'hBBBB);
    idle();

    // random traffic with occasional reset
    p0 = 0; p1 = 0;
    ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (p0 == 0 && $urandom_range(0, 9) < 6) begin
        p0 = 1; ra0 = 5'($urandom); rd0 = $urandom;
      end
      if (p1 == 0 && $urandom_range(0, 9) < 5) begin
        p1 = 1; ra1 = 5'($urandom); rd1 = $urandom;
      end
      r = ($urandom_range(0, 49) == 0);
      step(r, p0[0], ra0, rd0, p1[0], ra1, rd1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    idle();

    for (int i = 0; i < 32; i++)
      check($sformatf("rf[%0d]", i), 64'(rf_dut[i]), 64'(rf_ref[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
